lfsr_stream_checker: RTL and testbench
======================================

Name: lfsr_stream_checker

Overview:
- Receive end of the team's 8-bit Fibonacci LFSR random-number source.
- Takes the generator's serial output bit (state bit 0, one bit per generator step) and self-seeds from the first 8 bits.
- Confirms that later bits follow the LFSR recurrence, then reports lock, per-bit mismatches and loss of lock.
- Used on the reaction-timer board to check the random source during bring-up and in the field.

Parameters:
- CONFIRM_BITS, 16: consecutive correctly predicted bits needed in VERIFY before locked asserts (range 1..255).
- LOSS_THRESH, 4: consecutive mismatches in LOCKED that cause loss of lock (range 1..15).

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST_N  input  1  synchronous active-low reset, sampled on CLK rising edge.
- bit_valid  input  1  bit_in is valid this cycle; when low, nothing advances.
- bit_in  input  1  received LFSR output bit.
- locked  output  1  high while in LOCKED.
- bit_err  output  1  one-cycle pulse: the last valid bit mismatched in VERIFY or LOCKED.
- expected_bit  output  1  predicted value of the next valid bit (0 in SEED).
- state  output  2  00=SEED, 01=VERIFY, 10=LOCKED.
- err_count  output  16  total mismatches (see Optional Feature).

Behaviour:
- Reset: RST_N=0 at a rising edge clears all registers, forces state=SEED, and drives locked=0, bit_err=0, expected_bit=0, err_count=0. Reset mid-operation discards all history.
- Shift register R[7:0] holds received bits; R[0] is the oldest.
  - Shift operation: R <= {b, R[7:1]}.
  - Prediction: p = R[0]^R[3]^R[5]^R[7]. This matches the generator recurrence next[7] = s[0]^s[3]^s[5]^s[7] with a right shift.
- All state changes happen only on cycles with bit_valid=1. bit_err deasserts on any cycle without a mismatch.
- SEED:
  - Shift bit_in into R and increment a 3-bit seed counter.
  - On the 8th valid bit, check the assembled R value:
    - 0x00: illegal (stuck generator). Stay in SEED, counter restarts.
    - Otherwise: go to VERIFY and clear the match counter.
  - bit_err is never raised in SEED.
- VERIFY:
  - Compare bit_in with p, then shift bit_in into R.
  - Match: increment the match counter. When it reaches CONFIRM_BITS, go to LOCKED.
  - Mismatch: pulse bit_err, go to SEED, clear the seed counter. The bit is discarded.
- LOCKED (flywheel):
  - Shift p (not bit_in) into R, so corrupted bits do not corrupt the model.
  - Mismatch: pulse bit_err and increment a consecutive-error counter. When it reaches LOSS_THRESH, go to SEED and clear the counters.
  - Match: clear the consecutive-error counter.
- Latency:
  - bit_err, state and locked are registered. They update on the same edge that samples the valid bit and are visible the following cycle.
  - expected_bit is combinational from R, gated to 0 in SEED.
- Lock timing: with bit_valid high every cycle from reset release, locked first reads 1 after the (8+CONFIRM_BITS)-th valid edge.
- Simultaneous events: a mismatch that reaches LOSS_THRESH pulses bit_err and changes state on the same edge.

Optional Feature:
- Macro: LFSR_CHK_ERR_COUNT_EN.
- Defined:
  - err_count increments on every bit_err pulse and saturates at 0xFFFF (no wrap).
  - It is cleared only by reset and keeps its value across loss of lock.
- Undefined: err_count is tied to 0 and no counter logic is built.

Test Plan:
- Generator seeded 0x6A, bit_valid=1 continuously. First 8 bits are 0,1,0,1,0,1,1,0 (LSB first), giving R=0x6A. expected_bit in the first VERIFY cycle = 0. locked rises after valid edge 24. bit_err never pulses.
- Same stream, locked. Invert one bit -> single bit_err pulse, state stays LOCKED, err_count=1 (macro on). The following bits match because of the flywheel.
- Locked, then 4 consecutive inverted bits -> 4 bit_err pulses, state=SEED after the 4th, locked=0. A clean stream relocks after a further 24 bits.
- All-zero input for 40 cycles -> state stays SEED, locked=0, bit_err=0.
- Mid-VERIFY (after 5 matches), one inverted bit -> bit_err pulse, state=SEED. Toggle bit_valid 1/0 alternately -> lock takes 24 valid bits (48 cycles).
- RST_N low for one edge while LOCKED with err_count=3 -> next cycle state=SEED, locked=0, err_count=0, expected_bit=0.

Source files
------------

// File: rtl/lfsr_stream_checker.sv
// Receive-side checker for the 8-bit Fibonacci LFSR source: self-seeds, verifies, then flywheels.
// Optional mismatch counter on err_count is built when LFSR_CHK_ERR_COUNT_EN is defined.
module lfsr_stream_checker #(
    parameter int CONFIRM_BITS = 16,
    parameter int LOSS_THRESH  = 4
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        bit_valid,
    input  logic        bit_in,
    output logic        locked,
    output logic        bit_err,
    output logic        expected_bit,
    output logic [1:0]  state,
    output logic [15:0] err_count
);

    typedef enum logic [1:0] {
        ST_SEED   = 2'b00,
        ST_VERIFY = 2'b01,
        ST_LOCKED = 2'b10
    } state_t;

    state_t      r_state;
    logic [7:0]  r_sr;
    logic [2:0]  r_seed_cnt;
    logic [7:0]  r_match_cnt;
    logic [3:0]  r_loss_cnt;
    logic        r_bit_err;

    state_t      w_state_nxt;
    logic [7:0]  w_sr_nxt;
    logic [2:0]  w_seed_cnt_nxt;
    logic [7:0]  w_match_cnt_nxt;
    logic [3:0]  w_loss_cnt_nxt;
    logic        w_bit_err_nxt;

    logic        w_pred;
    logic        w_mismatch;
    logic [7:0]  w_sr_shift_in;
    logic [8:0]  w_match_inc;
    logic [4:0]  w_loss_inc;

    // R[0] is the oldest received bit, so the prediction is the generator's feedback term.
    assign w_pred        = r_sr[0] ^ r_sr[3] ^ r_sr[5] ^ r_sr[7];
    assign w_mismatch    = (bit_in != w_pred);
    assign w_sr_shift_in = {bit_in, r_sr[7:1]};
    assign w_match_inc   = {1'b0, r_match_cnt} + 9'd1;
    assign w_loss_inc    = {1'b0, r_loss_cnt} + 5'd1;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_state     <= ST_SEED;
            r_sr        <= '0;
            r_seed_cnt  <= '0;
            r_match_cnt <= '0;
            r_loss_cnt  <= '0;
            r_bit_err   <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_sr        <= w_sr_nxt;
            r_seed_cnt  <= w_seed_cnt_nxt;
            r_match_cnt <= w_match_cnt_nxt;
            r_loss_cnt  <= w_loss_cnt_nxt;
            r_bit_err   <= w_bit_err_nxt;
        end
    end

    // bit_valid qualifies bit_in: a cycle with bit_valid low advances nothing and
    // only lets bit_err fall; there is no backpressure toward the source.
    always_comb begin
        w_state_nxt     = r_state;
        w_sr_nxt        = r_sr;
        w_seed_cnt_nxt  = r_seed_cnt;
        w_match_cnt_nxt = r_match_cnt;
        w_loss_cnt_nxt  = r_loss_cnt;
        w_bit_err_nxt   = 1'b0;
        if (bit_valid) begin
            case (r_state)
                ST_SEED: begin
                    w_sr_nxt       = w_sr_shift_in;
                    w_seed_cnt_nxt = r_seed_cnt + 3'd1;
                    if (r_seed_cnt == 3'd7 && w_sr_shift_in != 8'h00) begin
                        w_state_nxt     = ST_VERIFY;
                        w_match_cnt_nxt = '0;
                    end
                end
                ST_VERIFY: begin
                    if (w_mismatch) begin
                        w_bit_err_nxt  = 1'b1;
                        w_state_nxt    = ST_SEED;
                        w_seed_cnt_nxt = '0;
                    end else begin
                        w_sr_nxt        = w_sr_shift_in;
                        w_match_cnt_nxt = w_match_inc[7:0];
                        if (w_match_inc == 9'(CONFIRM_BITS)) begin
                            w_state_nxt    = ST_LOCKED;
                            w_loss_cnt_nxt = '0;
                        end
                    end
                end
                ST_LOCKED: begin
                    // Flywheel: the model advances on its own prediction, not the received bit.
                    w_sr_nxt = {w_pred, r_sr[7:1]};
                    if (w_mismatch) begin
                        w_bit_err_nxt  = 1'b1;
                        w_loss_cnt_nxt = w_loss_inc[3:0];
                        if (w_loss_inc == 5'(LOSS_THRESH)) begin
                            w_state_nxt     = ST_SEED;
                            w_seed_cnt_nxt  = '0;
                            w_match_cnt_nxt = '0;
                            w_loss_cnt_nxt  = '0;
                        end
                    end else begin
                        w_loss_cnt_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt    = ST_SEED;
                    w_seed_cnt_nxt = '0;
                end
            endcase
        end
    end

    assign state        = r_state;
    assign locked       = (r_state == ST_LOCKED);
    assign bit_err      = r_bit_err;
    assign expected_bit = (r_state == ST_SEED) ? 1'b0 : w_pred;

`ifdef LFSR_CHK_ERR_COUNT_EN
    logic [15:0] r_err_count;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            r_err_count <= '0;
        end else if (w_bit_err_nxt && r_err_count != 16'hFFFF) begin
            r_err_count <= r_err_count + 16'd1;
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_lfsr_stream_checker.sv
// Directed bench for lfsr_stream_checker: seeding, lock timing, flywheel, loss of lock, reset.
// A local copy of the 8-bit generator supplies the source stream.
module tb_lfsr_stream_checker;

    logic        CLK = 1'b0;
    logic        RST_N = 1'b0;
    logic        bit_valid = 1'b0;
    logic        bit_in = 1'b0;
    logic        locked;
    logic        bit_err;
    logic        expected_bit;
    logic [1:0]  state;
    logic [15:0] err_count;

    int          n_vec = 0;
    int          n_mis = 0;
    logic [7:0]  g;
    logic [2:0]  exp_q[$];
    logic        err_seen;
    logic        lock_seen;
    logic        state_bad;

`ifdef LFSR_CHK_ERR_COUNT_EN
    localparam bit CNT_ON = 1'b1;
`else
    localparam bit CNT_ON = 1'b0;
`endif

    lfsr_stream_checker #(
        .CONFIRM_BITS(16),
        .LOSS_THRESH (4)
    ) dut (
        .CLK         (CLK),
        .RST_N       (RST_N),
        .bit_valid   (bit_valid),
        .bit_in      (bit_in),
        .locked      (locked),
        .bit_err     (bit_err),
        .expected_bit(expected_bit),
        .state       (state),
        .err_count   (err_count)
    );

    always #5 CLK = ~CLK;

    function automatic logic [15:0] exp_cnt(input int n);
        return CNT_ON ? 16'(n) : 16'd0;
    endfunction

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle, then sample 1 time unit after the rising edge.
    task automatic send(input logic v, input logic b);
        bit_valid = v;
        bit_in    = b;
        @(posedge CLK);
        #1;
    endtask

    // Emit the next generator bit (optionally inverted) and step the generator.
    task automatic send_gen(input logic inv);
        logic o;
        o = g[0];
        g = {g[0] ^ g[3] ^ g[5] ^ g[7], g[7:1]};
        send(1'b1, o ^ inv);
    endtask

    initial begin
        // Reset, with a valid bit presented to show reset dominates.
        RST_N = 1'b0;
        send(1'b0, 1'b0);
        send(1'b1, 1'b1);
        chk("rst_state", 16'(state), 16'd0);
        chk("rst_locked", 16'(locked), 16'd0);
        chk("rst_bit_err", 16'(bit_err), 16'd0);
        chk("rst_exp_bit", 16'(expected_bit), 16'd0);
        chk("rst_err_count", err_count, 16'd0);
        RST_N = 1'b1;

        // Clean stream from seed 0x6A: seed, verify, lock after edge 24.
        g = 8'h6A;
        err_seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            send_gen(1'b0);
            err_seen |= bit_err;
            if (i == 6) chk("seed_state_mid", 16'(state), 16'd0);
        end
        chk("seed_done_state", 16'(state), 16'd1);
        chk("verify_first_exp", 16'(expected_bit), 16'd0);
        for (int i = 0; i < 16; i++) begin
            chk("verify_pred", 16'(expected_bit), 16'(g[0]));
            send_gen(1'b0);
            err_seen |= bit_err;
            if (i == 14) chk("locked_early", 16'(locked), 16'd0);
        end
        chk("lock_at_24", 16'(locked), 16'd1);
        chk("lock_state", 16'(state), 16'd2);
        chk("clean_no_err", 16'(err_seen), 16'd0);

        // Single corrupted bit while locked: one pulse, lock held, flywheel keeps alignment.
        send_gen(1'b1);
        chk("glitch_err", 16'(bit_err), 16'd1);
        chk("glitch_state", 16'(state), 16'd2);
        chk("glitch_count", err_count, exp_cnt(1));
        for (int i = 0; i < 10; i++) begin
            chk("fly_pred", 16'(expected_bit), 16'(g[0]));
            send_gen(1'b0);
            chk("fly_no_err", 16'(bit_err), 16'd0);
        end
        chk("fly_state", 16'(state), 16'd2);

        // Four consecutive corrupted bits: loss of lock on the fourth.
        for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, (i < 3) ? 2'd2 : 2'd0});
        for (int i = 0; i < 4; i++) begin
            send_gen(1'b1);
            chk("loss_err_state", 16'({bit_err, state}), 16'(exp_q.pop_front()));
        end
        chk("loss_locked", 16'(locked), 16'd0);
        chk("loss_count", err_count, exp_cnt(5));
        for (int i = 0; i < 24; i++) begin
            send_gen(1'b0);
            if (i == 0) chk("relock_err_drop", 16'(bit_err), 16'd0);
            if (i == 22) chk("relock_early", 16'(locked), 16'd0);
        end
        chk("relock", 16'(locked), 16'd1);
        chk("count_kept", err_count, exp_cnt(5));

        // All-zero input never seeds.
        RST_N = 1'b0;
        send(1'b0, 1'b0);
        RST_N = 1'b1;
        chk("rst2_count", err_count, 16'd0);
        err_seen  = 1'b0;
        lock_seen = 1'b0;
        state_bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            send(1'b1, 1'b0);
            err_seen  |= bit_err;
            lock_seen |= locked;
            state_bad |= (state != 2'd0);
        end
        chk("zero_no_err", 16'(err_seen), 16'd0);
        chk("zero_no_lock", 16'(lock_seen), 16'd0);
        chk("zero_in_seed", 16'(state_bad), 16'd0);
        chk("zero_exp_bit", 16'(expected_bit), 16'd0);

        // Mismatch after 5 verify matches drops back to SEED.
        g = 8'h6A;
        for (int i = 0; i < 13; i++) send_gen(1'b0);
        chk("mid_verify_state", 16'(state), 16'd1);
        send_gen(1'b1);
        chk("verify_err", 16'(bit_err), 16'd1);
        chk("verify_to_seed", 16'(state), 16'd0);
        chk("verify_count", err_count, exp_cnt(1));
        send(1'b0, 1'($urandom_range(0, 1)));
        chk("err_drop_idle", 16'(bit_err), 16'd0);

        // Alternating valid: lock needs 24 valid bits regardless of idle cycles.
        for (int i = 0; i < 24; i++) begin
            send_gen(1'b0);
            if (i == 22) chk("toggle_early", 16'(locked), 16'd0);
            if (i == 7) chk("toggle_seeded", 16'(state), 16'd1);
            send(1'b0, 1'($urandom_range(0, 1)));
        end
        chk("toggle_lock", 16'(locked), 16'd1);

        // Two more isolated errors while locked, then reset mid-operation.
        send_gen(1'b1);
        send_gen(1'b0);
        send_gen(1'b1);
        chk("pre_rst_state", 16'(state), 16'd2);
        chk("pre_rst_count", err_count, exp_cnt(3));
        RST_N = 1'b0;
        send(1'b1, 1'b1);
        chk("rst3_state", 16'(state), 16'd0);
        chk("rst3_locked", 16'(locked), 16'd0);
        chk("rst3_count", err_count, 16'd0);
        chk("rst3_exp_bit", 16'(expected_bit), 16'd0);
        chk("rst3_bit_err", 16'(bit_err), 16'd0);
        RST_N = 1'b1;
        send(1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
